// File: rtl/matrix_reader.sv
// matrix_reader
// Streams a stored matrix out of an addressable buffer in row-major order.
// A frame walks read addresses from (0,0) to (row_max,col_max) with the
// column index running fastest. Each read goes to a memory with a 1-cycle
// read latency. The returned words are queued in a 3-entry FIFO and
// presented on a valid/ready stream, tagged with end-of-row and
// end-of-frame flags.
//
// Ports
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset
//   start      begin a frame (only honoured while idle)
//   row_max    last row index, captured when start is accepted
//   col_max    last column index, captured when start is accepted
//   busy       a frame is in progress
//   done       one-cycle pulse after the final element is accepted
//   rd_en      memory read strobe
//   rd_row     read row address (valid with rd_en)
//   rd_col     read column address (valid with rd_en)
//   rd_data    memory data, valid the cycle after rd_en
//   out_valid  stream element available
//   out_ready  downstream accepts on out_valid & out_ready
//   out_data   stream element
//   out_eol    element is the last column of its row
//   out_eof    element is the last element of the frame
module matrix_reader #(
  parameter int DATA_W = 16,
  parameter int DIM_W  = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [DIM_W-1:0]  row_max,
  input  logic [DIM_W-1:0]  col_max,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [DIM_W-1:0]  rd_row,
  output logic [DIM_W-1:0]  rd_col,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eol,
  output logic              out_eof
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Circular pointer advance over the three FIFO slots.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    logic [1:0] n;
    if (p == 2'd2) begin
      n = 2'd0;
    end else begin
      n = p + 2'd1;
    end
    return n;
  endfunction

  state_t             state_r;
  logic [DIM_W-1:0]   row_max_r;
  logic [DIM_W-1:0]   col_max_r;
  logic [DIM_W-1:0]   row_r;
  logic [DIM_W-1:0]   col_r;
  logic               rd_en_r;
  logic               busy_r;
  logic               done_r;

  logic               inflight_r;
  logic               inflight_eol_r;
  logic               inflight_eof_r;

  logic [2:0][DATA_W-1:0] fifo_data_r;
  logic [2:0]         fifo_eol_r;
  logic [2:0]         fifo_eof_r;
  logic [1:0]         wr_ptr_r;
  logic [1:0]         rd_ptr_r;
  logic [1:0]         count_r;
  logic               out_valid_r;

  logic               push_s;
  logic               pop_s;
  logic [1:0]         count_next_s;
  logic               credit_ok_s;
  logic               at_eol_s;
  logic               at_last_s;
  logic [DATA_W-1:0]  head_data_s;
  logic               head_eol_s;
  logic               head_eof_s;

  // Occupancy bookkeeping and the read-credit decision for the next cycle.
  always_comb begin
    push_s       = inflight_r;
    pop_s        = out_valid_r & out_ready;
    count_next_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
    // The read issued this cycle becomes next cycle's in-flight read, so
    // next cycle's credit counts it alongside next cycle's FIFO occupancy.
    // rd_en is registered from this, so out_ready never reaches it
    // combinationally.
    credit_ok_s  = ({1'b0, count_next_s} + {2'b00, rd_en_r}) < 3'd3;
    at_eol_s     = (col_r == col_max_r);
    at_last_s    = at_eol_s && (row_r == row_max_r);
  end

  // Frame control: state, latched maxima, address walk and read strobe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      row_max_r <= {DIM_W{1'b0}};
      col_max_r <= {DIM_W{1'b0}};
      row_r     <= {DIM_W{1'b0}};
      col_r     <= {DIM_W{1'b0}};
      rd_en_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            row_max_r <= row_max;
            col_max_r <= col_max;
            row_r     <= {DIM_W{1'b0}};
            col_r     <= {DIM_W{1'b0}};
            rd_en_r   <= credit_ok_s;
            busy_r    <= 1'b1;
            state_r   <= ST_ISSUE;
          end else begin
            rd_en_r <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (rd_en_r && at_last_s) begin
            // Final address has just been read; the address holds at the
            // maxima rather than wrapping.
            rd_en_r <= 1'b0;
            state_r <= ST_DRAIN;
          end else begin
            if (rd_en_r) begin
              if (at_eol_s) begin
                col_r <= {DIM_W{1'b0}};
                row_r <= row_r + DIM_W'(1'b1);
              end else begin
                col_r <= col_r + DIM_W'(1'b1);
              end
            end
            rd_en_r <= credit_ok_s;
          end
        end
        ST_DRAIN: begin
          rd_en_r <= 1'b0;
          // No read is outstanding here, so an empty FIFO after this
          // cycle's push/pop means the last element has been accepted.
          if (count_next_s == 2'd0) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          rd_en_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // In-flight stage: the eol/eof tags ride alongside the outstanding read.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inflight_r     <= 1'b0;
      inflight_eol_r <= 1'b0;
      inflight_eof_r <= 1'b0;
    end else begin
      inflight_r <= rd_en_r;
      if (rd_en_r) begin
        inflight_eol_r <= at_eol_s;
        inflight_eof_r <= at_last_s;
      end
    end
  end

  // Output FIFO: push returning read data, pop on a stream handshake.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fifo_data_r <= {(3*DATA_W){1'b0}};
      fifo_eol_r  <= 3'b000;
      fifo_eof_r  <= 3'b000;
      wr_ptr_r    <= 2'd0;
      rd_ptr_r    <= 2'd0;
      count_r     <= 2'd0;
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= rd_data;
        fifo_eol_r[wr_ptr_r]  <= inflight_eol_r;
        fifo_eof_r[wr_ptr_r]  <= inflight_eof_r;
        wr_ptr_r              <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r     <= count_next_s;
      out_valid_r <= (count_next_s != 2'd0);
    end
  end

  // FIFO head selection.
  always_comb begin
    head_data_s = {DATA_W{1'b0}};
    head_eol_s  = 1'b0;
    head_eof_s  = 1'b0;
    case (rd_ptr_r)
      2'd0: begin
        head_data_s = fifo_data_r[0];
        head_eol_s  = fifo_eol_r[0];
        head_eof_s  = fifo_eof_r[0];
      end
      2'd1: begin
        head_data_s = fifo_data_r[1];
        head_eol_s  = fifo_eol_r[1];
        head_eof_s  = fifo_eof_r[1];
      end
      2'd2: begin
        head_data_s = fifo_data_r[2];
        head_eol_s  = fifo_eol_r[2];
        head_eof_s  = fifo_eof_r[2];
      end
      default: begin
        head_data_s = {DATA_W{1'b0}};
        head_eol_s  = 1'b0;
        head_eof_s  = 1'b0;
      end
    endcase
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign rd_en     = rd_en_r;
  assign rd_row    = row_r;
  assign rd_col    = col_r;
  assign out_valid = out_valid_r;
  // Stale slot contents are masked so an empty stream reads as all zero.
  assign out_data  = out_valid_r ? head_data_s : {DATA_W{1'b0}};
  assign out_eol   = out_valid_r & head_eol_s;
  assign out_eof   = out_valid_r & head_eof_s;

endmodule

// File: doc/matrix_reader.md
# matrix_reader

Streams a stored matrix out of an addressable buffer in row-major order. On `start` it walks row/column read addresses from (0,0) to (`row_max`,`col_max`) and issues reads to a memory with 1-cycle read latency. It returns the data on a valid/ready stream tagged with end-of-row and end-of-frame flags. It is the read-side counterpart to the row/column write addressing that fills the operand buffers in front of the MACC array.

## Interface
- `DATA_W`, default 16: width of one matrix element.
- `DIM_W`, default 10: width of row/column indices and maxima.

- `CLK`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a frame; sampled only while `busy`=0.
- `row_max`  in  DIM_W  last row index (rows = `row_max`+1); latched on accepted `start`.
- `col_max`  in  DIM_W  last column index; latched on accepted `start`.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse after the final element is accepted downstream.
- `rd_en`  out  1  memory read strobe.
- `rd_row`  out  DIM_W  read row address; valid when `rd_en`=1.
- `rd_col`  out  DIM_W  read column address; valid when `rd_en`=1.
- `rd_data`  in  DATA_W  memory data, valid exactly one cycle after `rd_en`.
- `out_valid`  out  1  `out_data`/flags valid.
- `out_ready`  in  1  downstream accepts when `out_valid`&`out_ready`.
- `out_data`  out  DATA_W  element.
- `out_eol`  out  1  element is in column `col_max`.
- `out_eof`  out  1  element is (`row_max`,`col_max`).

## Operation
- State machine:
  - IDLE: `busy`=0. On `start`, latch maxima, clear row/col, and go to ISSUE.
  - ISSUE: issue reads. After the read of the last element, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight, then go to IDLE and pulse `done`.
- Address walk: column is fastest. If col==latched `col_max`, then col←0 and row←row+1; otherwise col←col+1. Last address is row==`row_max` && col==`col_max` (equality compares on latched values). Counters are DIM_W wide and never wrap past the maxima.
- Buffering: 3-entry output FIFO holding {data, eol, eof}.
  - Each issued read pushes one entry exactly one cycle later.
  - The eol/eof tags travel with the read through a 1-stage in-flight register.
- Credit rule: in ISSUE, `rd_en`=1 iff (fifo_count + inflight) < 3. The FIFO therefore never overflows and no combinational path exists from `out_ready` to `rd_en`.
- Stream: `out_valid` = FIFO non-empty. `out_data`/flags come from the FIFO head. Head and flags hold stable while `out_valid`=1 and `out_ready`=0.
- `start` while `busy`=1 is ignored, and input maxima changes mid-frame have no effect.
- Degenerate 1x1 (`row_max`=`col_max`=0): exactly one read and one output, with `out_eol`=`out_eof`=1.
- Reset (any time, including mid-frame): state goes to IDLE, FIFO is emptied, the in-flight read is discarded, and counters are cleared. The late `rd_data` is ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_en`=0, `rd_row`=0, `rd_col`=0, `out_valid`=0, `out_data`=0, `out_eol`=0, `out_eof`=0.
- Start is sampled in cycle 0:
  - Cycle 1: `busy`=1, `rd_en`=1 at (0,0).
  - Cycle 2: `rd_data` is valid and pushed at the end of the cycle.
  - Cycle 3: `out_valid`=1.
- With `out_ready` held high, throughput is 1 element/cycle. An R x C frame shows `rd_en` high for R*C consecutive cycles.
- If the final handshake (`out_eof` accepted) occurs in cycle N:
  - Cycle N+1: `done`=1, `busy`=0.
  - `start` is accepted in cycle N+1.
  - Back-to-back frames have exactly one idle cycle of `busy` gap.
- Backpressure: at most 3 elements are buffered. `rd_en` stalls within one cycle of the FIFO (plus in-flight read) reaching 3, and resumes the cycle after a pop frees credit.

## Test plan
- 2x3 frame (`row_max`=1, `col_max`=2), memory returns row*16+col, `out_ready`=1:
  - outputs 0x00,0x01,0x02,0x10,0x11,0x12;
  - `out_eol` on 0x02 and 0x12; `out_eof` only on 0x12;
  - `rd_en` high cycles 1-6; `done` in cycle 9.
- Same frame with `out_ready` low on cycles 3-8:
  - no more than 3 reads issued before cycle 9;
  - `out_data` holds 0x00 steady while stalled;
  - all 6 elements delivered in order, no loss or duplication.
- 1x1 frame: one `rd_en` at (0,0); one output with `out_eol`=`out_eof`=1; `done` 1 cycle after its handshake.
- `start` pulsed again in cycle 2 with `row_max`=5: ignored; the frame stays 2x3 and exactly 6 outputs are produced.
- `RST` asserted in cycle 4 of a 4x4 frame: all outputs go to 0 immediately. A fresh 2x2 frame then yields exactly 4 correct elements with no stale data.
- Back-to-back: a second `start` in the `done` cycle of the first frame is accepted, and its first `rd_en` follows in the next cycle.
